// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arbiter_pkg;

    localparam int SRAM_AW = 18;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sram_rr_grant.sv
// Two-way round-robin grant: on a tie the port not granted last wins.
module sram_rr_grant
    import sram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant,
    output logic last_grant
);

    // Pick a winner from the current requests and the previous grant.
    always_comb begin
        grant = PORT_A;
        if (req_a && req_b) begin
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant = PORT_B;
        end
    end

    // Remember who was granted; reset favours A on the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_B;
        end else if (advance) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU / loader) arbiter in front of an asynchronous SRAM.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer; arbitrate and latch the winner's request
// SETUP  | chip select + address out (and write data driven) for 1 cycle
// ACCESS | WAIT_CYCLES cycles of OE (read) or WE (write) strobe
// DONE   | strobes released, write data held, ack to granted port
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_a_cs,
    input  logic               i_a_we,
    input  logic [15:0]        i_a_addr,
    input  logic [7:0]         i_a_dat,
    output logic [7:0]         o_a_dat,
    output logic               o_a_ack,
    input  logic               i_b_cs,
    input  logic               i_b_we,
    input  logic [SRAM_AW-1:0] i_b_addr,
    input  logic [7:0]         i_b_dat,
    output logic [7:0]         o_b_dat,
    output logic               o_b_ack,
    output logic [SRAM_AW-1:0] o_addr,
    output logic [7:0]         o_dat,
    input  logic [7:0]         i_dat,
    output logic               o_dat_oe,
    output logic               sram_cs_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         wait_cnt;
    logic               start;
    logic               grant;
    logic               gnt_q;
    logic               we_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [7:0]         wdat_q;
    logic [7:0]         rdat_a_q;
    logic [7:0]         rdat_b_q;
    logic               access_last;

    // The last-grant register doubles as "port owning the current transfer".
    sram_rr_grant u_grant (
        .clk        (i_clk),
        .reset      (i_reset),
        .req_a      (i_a_cs),
        .req_b      (i_b_cs),
        .advance    (start),
        .grant      (grant),
        .last_grant (gnt_q)
    );

    assign access_last = (state == ACCESS) && (wait_cnt == 4'd0);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and SRAM strobe / ack decode.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        sram_cs_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        o_dat_oe  = 1'b0;
        o_a_ack   = 1'b0;
        o_b_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (i_a_cs || i_b_cs) begin
                    start     = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                sram_cs_n = 1'b0;
                o_dat_oe  = we_q;
                sram_oe_n = we_q;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                sram_cs_n = 1'b0;
                o_dat_oe  = we_q;
                sram_oe_n = we_q;
                sram_we_n = ~we_q;
                if (wait_cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_dat_oe  = we_q;
                o_a_ack   = (gnt_q == PORT_A);
                o_b_ack   = (gnt_q == PORT_B);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access-phase down-counter, loaded in SETUP, terminal count at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wait_cnt <= 4'd0;
        end else if (state == SETUP) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Latch the winner's request; later requester changes are ignored.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
        end else if (start) begin
            if (grant == PORT_A) begin
                we_q   <= i_a_we;
                addr_q <= {2'b00, i_a_addr};
                wdat_q <= i_a_dat;
            end else begin
                we_q   <= i_b_we;
                addr_q <= i_b_addr;
                wdat_q <= i_b_dat;
            end
        end
    end

    // Capture SRAM read data on the final access edge into the owner's register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rdat_a_q <= '0;
            rdat_b_q <= '0;
        end else if (access_last && !we_q) begin
            if (gnt_q == PORT_A) begin
                rdat_a_q <= i_dat;
            end else begin
                rdat_b_q <= i_dat;
            end
        end
    end

    assign o_addr  = addr_q;
    assign o_dat   = wdat_q;
    assign o_a_dat = rdat_a_q;
    assign o_b_dat = rdat_b_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: per-port scoreboards checked on ack.
module tb_sram_arbiter;

    localparam int W = 2;

    typedef struct packed {
        logic        we;
        logic [17:0] addr;
        logic [7:0]  dat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        a_cs, a_we, b_cs, b_we;
    logic [15:0] a_addr;
    logic [17:0] b_addr;
    logic [7:0]  a_dat, b_dat;
    logic [7:0]  o_a_dat, o_b_dat;
    logic        o_a_ack, o_b_ack;
    logic [17:0] o_addr;
    logic [7:0]  o_dat, i_dat;
    logic        o_dat_oe, sram_cs_n, sram_oe_n, sram_we_n;
    logic        force_en;
    logic [7:0]  force_val;

    logic        sm_cs     [2];
    logic [7:0]  sm_rdat   [2];
    logic        sm_ack    [2];
    logic [7:0]  sm_b_dat  [2];
    logic        sm_b_ack  [2];
    logic [17:0] sm_addr   [2];
    logic [7:0]  sm_odat   [2];
    logic        sm_oe     [2];
    logic        sm_csn    [2];
    logic        sm_oen    [2];
    logic        sm_wen    [2];

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int          we_cnt;
    logic [17:0] wr_addr;
    logic [7:0]  wr_dat;
    logic        prev_ack;

    function automatic logic [7:0] hash(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h5C;
    endfunction

    function automatic logic [7:0] rd_exp(input logic [17:0] a);
        return force_en ? force_val : hash(a);
    endfunction

    assign i_dat = force_en ? force_val : hash(o_addr);

    sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_cs(a_cs), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_dat(a_dat),
        .o_a_dat(o_a_dat), .o_a_ack(o_a_ack),
        .i_b_cs(b_cs), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_dat(b_dat),
        .o_b_dat(o_b_dat), .o_b_ack(o_b_ack),
        .o_addr(o_addr), .o_dat(o_dat), .i_dat(i_dat), .o_dat_oe(o_dat_oe),
        .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    for (genvar g = 0; g < 2; g++) begin : g_sm
        sram_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 15)) u_sm (
            .i_clk(clk), .i_reset(rst),
            .i_a_cs(sm_cs[g]), .i_a_we(1'b0), .i_a_addr(16'h0042), .i_a_dat(8'h00),
            .o_a_dat(sm_rdat[g]), .o_a_ack(sm_ack[g]),
            .i_b_cs(1'b0), .i_b_we(1'b0), .i_b_addr(18'h0), .i_b_dat(8'h00),
            .o_b_dat(sm_b_dat[g]), .o_b_ack(sm_b_ack[g]),
            .o_addr(sm_addr[g]), .o_dat(sm_odat[g]), .i_dat(8'(8'h3C + g)),
            .o_dat_oe(sm_oe[g]),
            .sram_cs_n(sm_csn[g]), .sram_oe_n(sm_oen[g]), .sram_we_n(sm_wen[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    a_ack_excl: assert property (@(posedge clk) disable iff (rst) !(o_a_ack && o_b_ack))
        else $error("FAIL assert ack_excl: got both acks expected one");
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(!sram_oe_n && !sram_we_n))
        else $error("FAIL assert strobe_excl: got oe_n=0 we_n=0 expected not both");

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic verify(input exp_t e, input logic [7:0] rdat);
        if (e.we) begin
            check_val("wr_addr", 32'(wr_addr), 32'(e.addr));
            check_val("wr_dat", 32'(wr_dat), 32'(e.dat));
            check_val("wr_we_cycles", 32'(we_cnt), 32'(W));
            check_val("wr_hold_oe", 32'(o_dat_oe), 32'd1);
            check_val("wr_hold_addr", 32'(o_addr), 32'(e.addr));
        end else begin
            check_val("rd_dat", 32'(rdat), 32'(e.dat));
            check_val("rd_no_we", 32'(we_cnt), 32'd0);
        end
    endtask

    // Bus monitor: invariants each cycle, scoreboard pop on each ack.
    always @(negedge clk) begin
        if (rst) begin
            we_cnt   = 0;
            prev_ack = 1'b0;
        end else begin
            check_val("ack_excl", 32'(o_a_ack & o_b_ack), 32'd0);
            check_val("strobe_excl", 32'(!sram_oe_n && !sram_we_n), 32'd0);
            check_val("ack_b2b", 32'((o_a_ack | o_b_ack) & prev_ack), 32'd0);
            if (!sram_we_n) begin
                we_cnt++;
                wr_addr = o_addr;
                wr_dat  = o_dat;
                check_val("we_dat_oe", 32'(o_dat_oe), 32'd1);
            end
            if (o_a_ack) begin
                if (sb_a.size() == 0) check_val("sb_a_unexpected_ack", 32'd1, 32'd0);
                else verify(sb_a.pop_front(), o_a_dat);
            end
            if (o_b_ack) begin
                if (sb_b.size() == 0) check_val("sb_b_unexpected_ack", 32'd1, 32'd0);
                else verify(sb_b.pop_front(), o_b_dat);
            end
            if (o_a_ack | o_b_ack) we_cnt = 0;
            prev_ack = o_a_ack | o_b_ack;
        end
    end

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        a_cs = 1'b0;
        b_cs = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_req(input logic port, input logic we, input logic [17:0] addr,
                            input logic [7:0] dat);
        exp_t e;
        e.we   = we;
        e.addr = addr;
        e.dat  = we ? dat : rd_exp(addr);
        if (port == 1'b0) begin
            a_we = we; a_addr = addr[15:0]; a_dat = dat; a_cs = 1'b1;
            sb_a.push_back(e);
        end else begin
            b_we = we; b_addr = addr; b_dat = dat; b_cs = 1'b1;
            sb_b.push_back(e);
        end
    endtask

    // One isolated transfer with latency and write-strobe timing checks.
    task automatic run_single(input logic port, input logic we, input logic [17:0] addr,
                              input logic [7:0] dat, input logic perturb,
                              input logic [31:0] exp_we_mask);
        int          k;
        logic        acked;
        logic [31:0] we_mask;
        @(negedge clk);
        push_req(port, we, addr, dat);
        k = 0; acked = 1'b0; we_mask = '0;
        while (!acked && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (!sram_we_n && k < 32) we_mask[k] = 1'b1;
            if (k == 1) begin
                check_val("setup_addr", 32'(o_addr), 32'(addr));
                check_val("setup_cs_n", 32'(sram_cs_n), 32'd0);
                if (perturb) begin
                    a_cs = 1'b0; b_cs = 1'b0;
                    a_we = ~a_we; b_we = ~b_we;
                    a_addr = ~a_addr; b_addr = ~b_addr;
                    a_dat = ~a_dat; b_dat = ~b_dat;
                end
            end
            if (port == 1'b0 ? o_a_ack : o_b_ack) acked = 1'b1;
        end
        if (port == 1'b0) a_cs = 1'b0; else b_cs = 1'b0;
        check_val("single_acked", 32'(acked), 32'd1);
        check_val("ack_cycle", 32'(k), 32'(W + 2));
        check_val("we_low_cycles", we_mask, exp_we_mask);
    endtask

    task automatic sm_latency(input int g, input int exp_cyc);
        int   k;
        logic acked;
        @(negedge clk);
        sm_cs[g] = 1'b1;
        k = 0; acked = 1'b0;
        while (!acked && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (sm_ack[g]) acked = 1'b1;
        end
        sm_cs[g] = 1'b0;
        check_val("sm_acked", 32'(acked), 32'd1);
        check_val("sm_latency", 32'(k), 32'(exp_cyc));
        check_val("sm_rdat", 32'(sm_rdat[g]), 32'(8'h3C + g));
    endtask

    task automatic rand_port(input logic port, input int n);
        int   t;
        logic ack;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_req(port, 1'($urandom_range(0, 1)),
                     port == 1'b0 ? {2'b00, 16'($urandom)} : 18'($urandom),
                     8'($urandom));
            t = 0;
            do begin
                @(negedge clk);
                t++;
                ack = (port == 1'b0) ? o_a_ack : o_b_ack;
            end while (!ack && t < 100);
            if (!ack) check_val("rand_timeout", 32'(port), 32'hFFFF_FFFF);
            if (port == 1'b0) a_cs = 1'b0; else b_cs = 1'b0;
        end
    endtask

    initial begin
        int   t;
        logic got;
        rst = 1'b1;
        a_cs = 0; a_we = 0; a_addr = '0; a_dat = '0;
        b_cs = 0; b_we = 0; b_addr = '0; b_dat = '0;
        force_en = 1'b0; force_val = '0;
        sm_cs[0] = 1'b0; sm_cs[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_cs_n", 32'(sram_cs_n), 32'd1);
        check_val("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_val("rst_we_n", 32'(sram_we_n), 32'd1);
        check_val("rst_dat_oe", 32'(o_dat_oe), 32'd0);
        check_val("rst_addr", 32'(o_addr), 32'd0);
        check_val("rst_dat", 32'(o_dat), 32'd0);
        check_val("rst_acks", 32'({o_a_ack, o_b_ack}), 32'd0);
        check_val("rst_rdat", 32'({o_a_dat, o_b_dat}), 32'd0);
        rst = 1'b0;

        run_single(1'b0, 1'b1, 18'h01234, 8'hA5, 1'b0, 32'hC);
        force_en = 1'b1; force_val = 8'h5A;
        run_single(1'b1, 1'b0, 18'h3FFFF, 8'h00, 1'b0, 32'h0);
        force_en = 1'b0;
        run_single(1'b0, 1'b0, 18'h000F0, 8'h00, 1'b1, 32'h0);
        run_single(1'b1, 1'b1, 18'h2ABCD, 8'h3C, 1'b1, 32'hC);
        check_val("b_rdat_persist", 32'(o_b_dat), 32'h5A);
        check_val("a_rdat_persist", 32'(o_a_dat), 32'(hash(18'h000F0)));

        sm_latency(0, 3);
        sm_latency(1, 17);

        reset_pulse();
        push_req(1'b0, 1'b0, 18'h00111, 8'h00);
        push_req(1'b1, 1'b0, 18'h20222, 8'h00);
        push_req(1'b0, 1'b0, 18'h00111, 8'h00);
        push_req(1'b1, 1'b0, 18'h20222, 8'h00);
        for (int i = 0; i < 4; i++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
                got = o_a_ack | o_b_ack;
            end while (!got && t < 50);
            check_val("rr_ack_seen", 32'(got), 32'd1);
            check_val("rr_order", 32'(o_b_ack), 32'(i % 2));
            if (i == 2) a_cs = 1'b0;
            if (i == 3) b_cs = 1'b0;
        end

        @(negedge clk);
        a_we = 1'b1; a_addr = 16'h0777; a_dat = 8'hC3; a_cs = 1'b1;
        repeat (2) @(negedge clk);
        check_val("abort_pre_we", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        a_cs = 1'b0;
        @(negedge clk);
        check_val("abort_we_n", 32'(sram_we_n), 32'd1);
        check_val("abort_dat_oe", 32'(o_dat_oe), 32'd0);
        check_val("abort_cs_n", 32'(sram_cs_n), 32'd1);
        check_val("abort_ack", 32'({o_a_ack, o_b_ack}), 32'd0);
        rst = 1'b0;
        run_single(1'b0, 1'b1, 18'h00778, 8'h3E, 1'b0, 32'hC);

        @(negedge clk);
        fork
            rand_port(1'b0, 12);
            rand_port(1'b1, 12);
        join
        repeat (3) @(negedge clk);
        check_val("sb_a_drained", 32'(sb_a.size()), 32'd0);
        check_val("sb_b_drained", 32'(sb_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
